// File: rtl/mips24_pkg.sv
// Shared widths and register-file typedefs for the mips24 datapath.
package mips24_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [CNT_W-1:0]  sb_cnt_t;

    localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register outstanding-write counters with sticky overflow/underflow flag.
module rf_scoreboard
    import mips24_pkg::*;
#(
    parameter int unsigned P_ADDR_W = mips24_pkg::ADDR_W,
    parameter int unsigned P_NREG   = mips24_pkg::NREG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_valid,
    input  logic [P_ADDR_W-1:0] inc_addr,
    input  logic                dec_valid,
    input  logic [P_ADDR_W-1:0] dec_addr,
    output logic [P_NREG-1:0]   busy,
    output logic                sb_err
);

    sb_cnt_t            r_cnt [P_NREG];
    logic               r_sb_err;
    sb_cnt_t            w_cnt_nxt [P_NREG];
    logic [P_NREG-1:0]  w_err_hit;

    // Next count per register; a simultaneous inc and dec cancel out.
    always_comb begin
        for (int unsigned r = 0; r < P_NREG; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            w_err_hit[r] = 1'b0;
            if (inc_valid && (inc_addr == P_ADDR_W'(r)) &&
                !(dec_valid && (dec_addr == P_ADDR_W'(r)))) begin
                if (r_cnt[r] == SB_CNT_MAX) w_err_hit[r] = 1'b1;
                else                        w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
            end else if (dec_valid && (dec_addr == P_ADDR_W'(r)) &&
                         !(inc_valid && (inc_addr == P_ADDR_W'(r)))) begin
                if (r_cnt[r] == '0) w_err_hit[r] = 1'b1;
                else                w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
            end
        end
    end

    // Counter and sticky error state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < P_NREG; r++) r_cnt[r] <= '0;
            r_sb_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < P_NREG; r++) r_cnt[r] <= w_cnt_nxt[r];
            if (|w_err_hit) r_sb_err <= 1'b1;
        end
    end

    // A register is busy while any write to it is outstanding.
    always_comb begin
        for (int unsigned r = 0; r < P_NREG; r++) busy[r] = (r_cnt[r] != '0);
    end

    assign sb_err = r_sb_err;

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
module rf_write_arbiter
    import mips24_pkg::*;
#(
    parameter int unsigned DATA_W = mips24_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips24_pkg::ADDR_W,
    parameter int unsigned NREG   = mips24_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_rd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,
    output logic [NREG-1:0]   busy,
    output logic              sb_err
);

    logic              r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic              w_gnt0;
    logic              w_gnt1;

    // Lone requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
        w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Output register and round-robin pointer; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_rd         <= '0;
            r_data       <= '0;
        end else if (w_gnt0) begin
            r_last_grant <= 1'b0;
            r_we         <= 1'b1;
            r_rd         <= req0_rd;
            r_data       <= req0_data;
        end else if (w_gnt1) begin
            r_last_grant <= 1'b1;
            r_we         <= 1'b1;
            r_rd         <= req1_rd;
            r_data       <= req1_data;
        end else begin
            r_we         <= 1'b0;
        end
    end

    assign rf_we   = r_we;
    assign rf_rd   = r_rd;
    assign rf_data = r_data;

    // Pending writes retire on the edge the register file captures them.
    rf_scoreboard #(
        .P_ADDR_W (ADDR_W),
        .P_NREG   (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_valid (alloc_valid),
        .inc_addr  (alloc_rd),
        .dec_valid (r_we),
        .dec_addr  (r_rd),
        .busy      (busy),
        .sb_err    (sb_err)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a cycle-level reference model.
module tb_rf_write_arbiter;

    localparam int unsigned DW = 24;
    localparam int unsigned AW = 3;
    localparam int unsigned NR = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, alloc_valid;
    logic [AW-1:0] req0_rd, req1_rd, alloc_rd;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic [NR-1:0] busy;
    logic          sb_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit            m_init = 1'b0;
    int            m_cnt [NR];
    bit            m_err;
    bit            m_lg;
    bit            m_we;
    int unsigned   m_rd;
    int unsigned   m_data;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_rd     (req0_rd),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_rd     (req1_rd),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_data     (rf_data),
        .busy        (busy),
        .sb_err      (sb_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which port wins: bit0 = port 0, bit1 = port 1.
    function automatic logic [1:0] winner(input bit v0, input bit v1, input bit lg);
        if (v0 && v1) return lg ? 2'b01 : 2'b10;
        return {v1, v0};
    endfunction

    // Model: advance on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        logic [1:0] g;
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_err = 0; m_lg = 1; m_we = 0; m_rd = 0; m_data = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            for (int r = 0; r < NR; r++) begin
                bit inc, dec;
                inc = alloc_valid && (int'(alloc_rd) == r);
                dec = m_we && (m_rd == r);
                if (inc && !dec) begin
                    if (m_cnt[r] == 3) m_err = 1; else m_cnt[r] = m_cnt[r] + 1;
                end else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_err = 1; else m_cnt[r] = m_cnt[r] - 1;
                end
            end
            g = winner(req0_valid, req1_valid, m_lg);
            if (g[0]) begin
                m_we = 1; m_rd = req0_rd; m_data = req0_data; m_lg = 0;
            end else if (g[1]) begin
                m_we = 1; m_rd = req1_rd; m_data = req1_data; m_lg = 1;
            end else begin
                m_we = 0;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (m_init) begin
            logic [1:0]    g;
            logic [NR-1:0] eb;
            g = winner(req0_valid, req1_valid, m_lg);
            for (int r = 0; r < NR; r++) eb[r] = (m_cnt[r] != 0);
            check("req0_ready", 32'(req0_ready), 32'(g[0]));
            check("req1_ready", 32'(req1_ready), 32'(g[1]));
            check("rf_we",      32'(rf_we),      32'(m_we));
            check("rf_rd",      32'(rf_rd),      m_rd);
            check("rf_data",    32'(rf_data),    m_data);
            check("busy",       32'(busy),       32'(eb));
            check("sb_err",     32'(sb_err),     32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; alloc_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        req0_valid = 0; req0_rd = '0; req0_data = '0;
        req1_valid = 0; req1_rd = '0; req1_data = '0;
        alloc_valid = 0; alloc_rd = '0;
        step(); step();
        rst_n = 1;
        check("reset_we",     32'(rf_we),  32'd0);
        check("reset_busy",   32'(busy),   32'h00);
        check("reset_sb_err", 32'(sb_err), 32'd0);
        step();

        // Allocate targets for the contention and single-port writes.
        alloc_valid = 1;
        alloc_rd = 3'd1; step();
        alloc_rd = 3'd1; step();
        alloc_rd = 3'd2; step();
        alloc_rd = 3'd2; step();
        alloc_rd = 3'd7; step();
        alloc_valid = 0;
        check("alloc_busy", 32'(busy), 32'h86);

        // Contention: port 0 wins first tie, then strict alternation.
        req0_valid = 1; req0_rd = 3'd1; req0_data = 24'd11;
        req1_valid = 1; req1_rd = 3'd2; req1_data = 24'd22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("tie_ready0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            step();
            check("tie_rf_rd", 32'(rf_rd), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle_inputs();

        // Single port 0 write.
        req0_valid = 1; req0_rd = 3'd7; req0_data = 24'd100;
        #1;
        check("single_ready0", 32'(req0_ready), 32'd1);
        step();
        idle_inputs();
        check("single_we",   32'(rf_we),   32'd1);
        check("single_rd",   32'(rf_rd),   32'd7);
        check("single_data", 32'(rf_data), 32'd100);
        step();
        check("single_we_drop", 32'(rf_we),  32'd0);
        check("drained_busy",   32'(busy),   32'h00);
        check("no_err_yet",     32'(sb_err), 32'd0);

        // Scoreboard: two allocs on r5, then two writes.
        alloc_valid = 1; alloc_rd = 3'd5; step(); step();
        alloc_valid = 0;
        req1_valid = 1; req1_rd = 3'd5; req1_data = 24'd55;
        step();
        check("sb5_after_hs1", 32'(busy[5]), 32'd1);
        step();
        idle_inputs();
        check("sb5_after_wr1", 32'(busy[5]), 32'd1);
        step();
        check("sb5_after_wr2", 32'(busy[5]), 32'd0);

        // Simultaneous alloc and commit on r5 leaves the count unchanged.
        alloc_valid = 1; alloc_rd = 3'd5; step();
        alloc_valid = 0;
        req1_valid = 1; step();
        req1_valid = 0; alloc_valid = 1; step();
        alloc_valid = 0;
        check("sb5_cancel", 32'(busy[5]), 32'd1);
        step();
        check("sb5_hold", 32'(busy[5]), 32'd1);
        req0_valid = 1; req0_rd = 3'd5; req0_data = 24'hABCDEF; step();
        idle_inputs(); step();
        check("sb5_final", 32'(busy), 32'h00);

        // Overflow: four allocs on r3.
        alloc_valid = 1; alloc_rd = 3'd3;
        repeat (4) step();
        alloc_valid = 0;
        check("ovf_busy3", 32'(busy[3]), 32'd1);
        check("ovf_err",   32'(sb_err),  32'd1);

        // Underflow after reset: write r4 with nothing pending.
        rst_n = 0; step(); rst_n = 1;
        check("rst_err_clr", 32'(sb_err), 32'd0);
        req0_valid = 1; req0_rd = 3'd4; req0_data = 24'd44; step();
        idle_inputs(); step();
        check("udf_err",  32'(sb_err), 32'd1);
        check("udf_busy", 32'(busy),   32'h00);

        // Reset on the handshake edge of port 1 drops the write.
        alloc_valid = 1; alloc_rd = 3'd6; step();
        alloc_valid = 0;
        req1_valid = 1; req1_rd = 3'd6; req1_data = 24'd66;
        rst_n = 0; step();
        rst_n = 1; idle_inputs();
        check("mid_rst_we",   32'(rf_we), 32'd0);
        check("mid_rst_busy", 32'(busy),  32'h00);
        step();
        check("mid_rst_we2",  32'(rf_we), 32'd0);

        // Mixed traffic against the model.
        for (int i = 0; i < 40; i++) begin
            req0_valid  = 1'($urandom_range(0, 1));
            req1_valid  = 1'($urandom_range(0, 1));
            alloc_valid = 1'($urandom_range(0, 1));
            req0_rd   = 3'($urandom_range(0, 7));
            req1_rd   = 3'($urandom_range(0, 7));
            alloc_rd  = 3'($urandom_range(0, 7));
            req0_data = 24'($urandom);
            req1_data = 24'($urandom);
            step();
        end
        idle_inputs();
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the 8×24-bit register file between two writeback producers: port 0 is ALU writeback, port 1 is load writeback. The block does round-robin arbitration with valid/ready handshakes and drives registered `rf_we`/`rf_rd`/`rf_data` into the register file. It also keeps a per-register pending-write scoreboard so decode can stall on RAW hazards. It sits between the execute/memory stages and the register file write port.

## Interface
Parameters:
- DATA_W, 24, register data width
- ADDR_W, 3, register address width
- NREG, 8, register count (2**ADDR_W)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  ALU writeback request
- req0_rd  in  ADDR_W  destination register
- req0_data  in  DATA_W  write data
- req0_ready  out  1  grant/accept for port 0 (combinational)
- req1_valid, req1_rd, req1_data, req1_ready  same as above, load writeback
- alloc_valid  in  1  decode issued an instruction that will write alloc_rd
- alloc_rd  in  ADDR_W  register being allocated
- rf_we  out  1  write enable to register file (registered)
- rf_rd  out  ADDR_W  write address (registered)
- rf_data  out  DATA_W  write data (registered)
- busy  out  NREG  busy[r]=1 while ≥1 write to r is outstanding
- sb_err  out  1  sticky: scoreboard overflow or underflow

## Operation
- Handshake: a transfer on port i occurs when reqi_valid && reqi_ready at a posedge. reqi_ready depends only on both valids and last_grant. The block never back-pressures for any other reason.
- Arbitration: only one valid → that port is granted. Both valid → grant the port ≠ last_grant. last_grant updates only on a transfer.
- Output register: on a transfer, rf_we←1, rf_rd←granted rd, rf_data←granted data. With no transfer, rf_we←0 and rf_rd/rf_data hold their values.
- No r0 special-casing: writes to r0 pass through unchanged.
- Scoreboard: one 2-bit outstanding-write counter per register.
  - Increment on alloc_valid for alloc_rd.
  - Decrement when rf_we=1 for rf_rd, i.e. at the edge the register file captures the data.
  - Increment and decrement on the same register in the same cycle → counter unchanged.
  - Increment at count 3 → ignored, sb_err←1.
  - Decrement at count 0 → ignored, sb_err←1.
- busy[r] = (count[r] != 0), combinational from the counters.
- Write ordering to the same rd across ports is not enforced; producers are responsible for it.

## Timing
- Reset (rst_n=0 at posedge): rf_we=0, rf_rd=0, rf_data=0, all counters 0 (busy=0), sb_err=0, last_grant=1 (port 0 wins the first tie). reqi_ready is still combinational during reset, but transfers in reset cycles are discarded.
- Reset mid-operation: a transfer at the reset edge is lost. rf_we is 0 after that edge and pending counts clear.
- Latency: handshake at edge N → rf_we=1 in cycle N..N+1 → register file writes at edge N+1. busy for that register drops after edge N+1 if its count reaches 0.
- Throughput: one write per cycle. Under continuous contention, ports alternate every cycle.
- alloc at edge N → busy visible in cycle after N.

## Structure
- Shared package mips24_pkg: DATA_W, ADDR_W, NREG, and the reg_addr_t/reg_data_t typedefs, shared with regFile.
- Sub-module rf_scoreboard holds the NREG 2-bit counters, busy, and sb_err; inputs are inc(valid, addr) and dec(valid, addr).
- The top level holds the arbiter, last_grant, and the output register.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles → rf_we=0, busy=8'h00, sb_err=0, both ready follow valid.
- Single port: req0 (rd=7, data=100) for one cycle → req0_ready=1, next cycle rf_we=1, rf_rd=7, rf_data=100; the following cycle rf_we=0.
- Contention: both valid for 4 cycles (req0 rd=1/data=11, req1 rd=2/data=22) → grants 0,1,0,1; rf_rd sequence 1,2,1,2.
- Scoreboard: alloc rd=5 twice, then two writes to 5 → busy[5]=1 until the edge after the second rf_we, then 0. Simultaneous alloc and commit on rd=5 → count unchanged.
- Overflow/underflow: 4 allocs on rd=3 → count stays 3, sb_err=1. After reset, a write to rd=4 with count 0 → sb_err=1, busy unchanged.
- Reset mid-transfer: rst_n=0 on the handshake edge of req1 (rd=6) → rf_we stays 0, busy=0 afterward.
